// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM: Moore-decoded datapath controls, registered one
// cycle ahead from the next state, plus retired-instruction counter and illegal-opcode pulse.
module main_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  output logic [1:0]  ALUOp,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCUpdate,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        Branch,
  output logic        BranchType,
  output logic [3:0]  state_o,
  output logic [31:0] instret,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       branch_type;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BLT = 3'b100;

  function automatic logic is_legal(input logic [6:0] opc);
    case (opc)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH: is_legal = 1'b1;
      default:                                                  is_legal = 1'b0;
    endcase
  endfunction

  function automatic state_t next_state(input state_t s, input logic [6:0] opc);
    next_state = S_FETCH;
    case (s)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        case (opc)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECUTER;
          OP_ITYPE:          next_state = S_EXECUTEI;
          OP_JAL:            next_state = S_JAL;
          OP_BRANCH:         next_state = S_BRANCH;
          default:           next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = (opc == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state = S_MEMWB;
      S_EXECUTER: next_state = S_ALUWB;
      S_EXECUTEI: next_state = S_ALUWB;
      S_JAL:      next_state = S_ALUWB;
      default:    next_state = S_FETCH;
    endcase
  endfunction

  // An instruction retires on the edge that leaves one of its final states.
  function automatic logic retires(input state_t s);
    case (s)
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH: retires = 1'b1;
      default:                                retires = 1'b0;
    endcase
  endfunction

  function automatic ctrl_t decode_ctrl(input state_t s, input logic [2:0] f3);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.pc_update  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD: c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: c.reg_write = 1'b1;
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 2'b10;
        case (f3)
          F3_BEQ: begin
            c.alu_op = 2'b01;
            c.branch = 1'b1;
          end
          F3_BLT: begin
            c.alu_op      = 2'b10;
            c.branch      = 1'b1;
            c.branch_type = 1'b1;
          end
          default: c.branch = 1'b0;
        endcase
      end
      default: c = '0;
    endcase
    decode_ctrl = c;
  endfunction

  state_t      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] instret_q, instret_d;
  logic        illegal_q, illegal_d;

  // Controls are decoded from the next state so the registered copy lines up with
  // state_q; funct3 is stable in the instruction register for the whole instruction.
  always_comb begin
    state_d   = next_state(state_q, op);
    ctrl_d    = decode_ctrl(state_d, funct3);
    illegal_d = (state_q == S_DECODE) && !is_legal(op);
    instret_d = retires(state_q) ? instret_q + 32'd1 : instret_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= decode_ctrl(S_FETCH, 3'b000);
      instret_q <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  assign ALUOp      = ctrl_q.alu_op;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign ResultSrc  = ctrl_q.result_src;
  assign AdrSrc     = ctrl_q.adr_src;
  assign IRWrite    = ctrl_q.ir_write;
  assign PCUpdate   = ctrl_q.pc_update;
  assign RegWrite   = ctrl_q.reg_write;
  assign MemWrite   = ctrl_q.mem_write;
  assign Branch     = ctrl_q.branch;
  assign BranchType = ctrl_q.branch_type;
  assign state_o    = state_q;
  assign instret    = instret_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: stimulus queues per-cycle expectations, a
// negedge monitor pops and compares state, control vector, instret and illegal.
module tb_main_fsm;

  logic        clk;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [1:0]  ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
  logic        AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, Branch, BranchType;
  logic [3:0]  state_o;
  logic [31:0] instret;
  logic        illegal;

  main_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Branch(Branch), .BranchType(BranchType),
    .state_o(state_o), .instret(instret), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
                         ST_MEMREAD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWRITE = 4'd5,
                         ST_EXECR = 4'd6, ST_ALUWB = 4'd7, ST_EXECI = 4'd8,
                         ST_JAL = 4'd9, ST_BRANCH = 4'd10;

  // {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, Branch, BranchType}
  localparam logic [14:0] C_FETCH  = 15'b00_00_10_10_0_1_1_0_0_0_0;
  localparam logic [14:0] C_DECODE = 15'b00_01_01_00_0_0_0_0_0_0_0;
  localparam logic [14:0] C_MEMADR = 15'b00_10_01_00_0_0_0_0_0_0_0;
  localparam logic [14:0] C_MEMRD  = 15'b00_00_00_00_1_0_0_0_0_0_0;
  localparam logic [14:0] C_MEMWB  = 15'b00_00_00_01_0_0_0_1_0_0_0;
  localparam logic [14:0] C_MEMWR  = 15'b00_00_00_00_1_0_0_0_1_0_0;
  localparam logic [14:0] C_EXECR  = 15'b10_10_00_00_0_0_0_0_0_0_0;
  localparam logic [14:0] C_EXECI  = 15'b10_10_01_00_0_0_0_0_0_0_0;
  localparam logic [14:0] C_ALUWB  = 15'b00_00_00_00_0_0_0_1_0_0_0;
  localparam logic [14:0] C_JAL    = 15'b00_01_10_00_0_0_1_0_0_0_0;
  localparam logic [14:0] C_BEQ    = 15'b01_10_00_00_0_0_0_0_0_1_0;
  localparam logic [14:0] C_BLT    = 15'b10_10_00_00_0_0_0_0_0_1_1;
  localparam logic [14:0] C_BNONE  = 15'b00_10_00_00_0_0_0_0_0_0_0;

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] ctrl;
    logic [31:0] ir;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, req);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic [14:0] ctrl,
                      input logic [31:0] ir, input logic ill);
    exp_t e;
    e.st = st; e.ctrl = ctrl; e.ir = ir; e.ill = ill;
    sb_q.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] st, input logic [14:0] ctrl,
                     input logic [31:0] ir, input logic ill);
    @(posedge clk);
    #1;
    push(st, ctrl, ir, ill);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("state_o", {28'd0, state_o}, {28'd0, e.st});
      check("ctrl", {17'd0, ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite,
                     PCUpdate, RegWrite, MemWrite, Branch, BranchType}, {17'd0, e.ctrl});
      check("instret", instret, e.ir);
      check("illegal", {31'd0, illegal}, {31'd0, e.ill});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; op = OP_LW; funct3 = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    push(ST_FETCH, C_FETCH, 32'd0, 1'b0);
    reset = 1'b0;

    // lw
    cyc(ST_DECODE,  C_DECODE, 32'd0, 1'b0);
    cyc(ST_MEMADR,  C_MEMADR, 32'd0, 1'b0);
    cyc(ST_MEMREAD, C_MEMRD,  32'd0, 1'b0);
    cyc(ST_MEMWB,   C_MEMWB,  32'd0, 1'b0);
    cyc(ST_FETCH,   C_FETCH,  32'd1, 1'b0);
    // sw
    op = OP_SW;
    cyc(ST_DECODE,   C_DECODE, 32'd1, 1'b0);
    cyc(ST_MEMADR,   C_MEMADR, 32'd1, 1'b0);
    cyc(ST_MEMWRITE, C_MEMWR,  32'd1, 1'b0);
    cyc(ST_FETCH,    C_FETCH,  32'd2, 1'b0);
    // R-type then I-type
    op = OP_R;
    cyc(ST_DECODE, C_DECODE, 32'd2, 1'b0);
    cyc(ST_EXECR,  C_EXECR,  32'd2, 1'b0);
    cyc(ST_ALUWB,  C_ALUWB,  32'd2, 1'b0);
    cyc(ST_FETCH,  C_FETCH,  32'd3, 1'b0);
    op = OP_I;
    cyc(ST_DECODE, C_DECODE, 32'd3, 1'b0);
    cyc(ST_EXECI,  C_EXECI,  32'd3, 1'b0);
    cyc(ST_ALUWB,  C_ALUWB,  32'd3, 1'b0);
    cyc(ST_FETCH,  C_FETCH,  32'd4, 1'b0);
    // branches: beq, blt, unsupported funct3
    op = OP_BR; funct3 = 3'b000;
    cyc(ST_DECODE, C_DECODE, 32'd4, 1'b0);
    cyc(ST_BRANCH, C_BEQ,    32'd4, 1'b0);
    cyc(ST_FETCH,  C_FETCH,  32'd5, 1'b0);
    funct3 = 3'b100;
    cyc(ST_DECODE, C_DECODE, 32'd5, 1'b0);
    cyc(ST_BRANCH, C_BLT,    32'd5, 1'b0);
    cyc(ST_FETCH,  C_FETCH,  32'd6, 1'b0);
    funct3 = 3'b010;
    cyc(ST_DECODE, C_DECODE, 32'd6, 1'b0);
    cyc(ST_BRANCH, C_BNONE,  32'd6, 1'b0);
    cyc(ST_FETCH,  C_FETCH,  32'd7, 1'b0);
    // illegal opcode: one-cycle pulse, no retire
    op = OP_BAD; funct3 = 3'b000;
    cyc(ST_DECODE, C_DECODE, 32'd7, 1'b0);
    cyc(ST_FETCH,  C_FETCH,  32'd7, 1'b1);
    op = OP_LW;
    cyc(ST_DECODE,  C_DECODE, 32'd7, 1'b0);
    cyc(ST_MEMADR,  C_MEMADR, 32'd7, 1'b0);
    cyc(ST_MEMREAD, C_MEMRD,  32'd7, 1'b0);
    // reset in the middle of a load
    reset = 1'b1;
    cyc(ST_FETCH, C_FETCH, 32'd0, 1'b0);
    reset = 1'b0;
    // jal with instret preloaded to all-ones
    op = OP_JAL;
    @(negedge clk);
    #1 force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    cyc(ST_DECODE, C_DECODE, 32'hFFFF_FFFF, 1'b0);
    cyc(ST_JAL,    C_JAL,    32'hFFFF_FFFF, 1'b0);
    cyc(ST_ALUWB,  C_ALUWB,  32'hFFFF_FFFF, 1'b0);
    cyc(ST_FETCH,  C_FETCH,  32'h0000_0000, 1'b0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
